// File: rtl/lpc_host.sv
// LPC host initiator for single-byte 16-bit I/O read/write cycles.
// Local valid/ready request in, one response pulse per completed or aborted cycle.
module lpc_host #(
   parameter int unsigned SHORT_WAIT_MAX = 31,
   parameter int unsigned NO_RESP_MAX    = 3
) (
   input  logic        lpc_clock,
   input  logic        lpc_reset,
   input  logic [3:0]  lpc_ad_in,
   output logic [3:0]  lpc_ad_out,
   output logic        lpc_ad_oe,
   output logic        lpc_frame,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_error,
   output logic        rsp_abort
);
   localparam int unsigned SW_W = $clog2(SHORT_WAIT_MAX + 1);
   localparam int unsigned NR_W = $clog2(NO_RESP_MAX + 1);

   localparam logic [3:0] SYNC_READY = 4'b0000;
   localparam logic [3:0] SYNC_SHORT = 4'b0101;
   localparam logic [3:0] SYNC_LONG  = 4'b0110;
   localparam logic [3:0] SYNC_ERROR = 4'b1010;
   localparam logic [3:0] SYNC_NONE  = 4'b1111;

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_CYCTYPE, S_ADDR, S_WDATA, S_HTAR0, S_HTAR1,
      S_SYNC, S_RDATA, S_PTAR0, S_PTAR1, S_ABORT, S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [1:0]        cnt, cnt_nxt;
   logic [SW_W-1:0]   sw_cnt, sw_nxt;
   logic [NR_W-1:0]   nr_cnt, nr_nxt;
   logic              err_q, err_nxt;
   logic              abt_q, abt_nxt;
   logic [7:0]        rdata_q, rdata_nxt;
   logic              write_q;
   logic [15:0]       addr_q;
   logic [7:0]        wdata_q;
   logic              accept;
   logic              go_abort;
   logic [3:0]        ad_nxt;

   // Next-state, counters and response flags
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sw_nxt    = sw_cnt;
      nr_nxt    = nr_cnt;
      err_nxt   = err_q;
      abt_nxt   = abt_q;
      rdata_nxt = rdata_q;
      accept    = 1'b0;
      go_abort  = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               accept    = 1'b1;
               state_nxt = S_START;
               cnt_nxt   = '0;
               sw_nxt    = '0;
               nr_nxt    = '0;
               err_nxt   = 1'b0;
               abt_nxt   = 1'b0;
               rdata_nxt = 8'h00;
            end
         end
         S_START:   state_nxt = S_CYCTYPE;
         S_CYCTYPE: begin
            state_nxt = S_ADDR;
            cnt_nxt   = '0;
         end
         S_ADDR: begin
            if (cnt == 2'd3) begin
               state_nxt = write_q ? S_WDATA : S_HTAR0;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 2'd1;
            end
         end
         S_WDATA: begin
            if (cnt == 2'd1) begin
               state_nxt = S_HTAR0;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 2'd1;
            end
         end
         S_HTAR0: state_nxt = S_HTAR1;
         S_HTAR1: state_nxt = S_SYNC;
         // Short-wait and no-response runs reset each other; long wait clears both
         S_SYNC: begin
            case (lpc_ad_in)
               SYNC_READY, SYNC_ERROR: begin
                  err_nxt   = (lpc_ad_in == SYNC_ERROR);
                  state_nxt = write_q ? S_PTAR0 : S_RDATA;
                  cnt_nxt   = '0;
               end
               SYNC_SHORT: begin
                  nr_nxt = '0;
                  sw_nxt = sw_cnt + SW_W'(1);
                  if (sw_nxt == SW_W'(SHORT_WAIT_MAX)) go_abort = 1'b1;
               end
               SYNC_LONG: begin
                  sw_nxt = '0;
                  nr_nxt = '0;
               end
               SYNC_NONE: begin
                  sw_nxt = '0;
                  nr_nxt = nr_cnt + NR_W'(1);
                  if (nr_nxt == NR_W'(NO_RESP_MAX)) go_abort = 1'b1;
               end
               default: go_abort = 1'b1;
            endcase
            if (go_abort) begin
               state_nxt = S_ABORT;
               cnt_nxt   = '0;
               abt_nxt   = 1'b1;
               err_nxt   = 1'b1;
            end
         end
         S_RDATA: begin
            if (cnt == 2'd0) begin
               rdata_nxt = {rdata_q[7:4], lpc_ad_in};
               cnt_nxt   = 2'd1;
            end else begin
               rdata_nxt = {lpc_ad_in, rdata_q[3:0]};
               cnt_nxt   = '0;
               state_nxt = S_PTAR0;
            end
         end
         S_PTAR0: state_nxt = S_PTAR1;
         S_PTAR1: state_nxt = S_DONE;
         S_ABORT: begin
            if (cnt == 2'd3) begin
               state_nxt = S_DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 2'd1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Nibble the bus will carry in the upcoming state
   always_comb begin
      ad_nxt = 4'hF;
      case (state_nxt)
         S_START:   ad_nxt = 4'h0;
         S_CYCTYPE: ad_nxt = write_q ? 4'h2 : 4'h0;
         S_ADDR: begin
            case (cnt_nxt)
               2'd0:    ad_nxt = addr_q[15:12];
               2'd1:    ad_nxt = addr_q[11:8];
               2'd2:    ad_nxt = addr_q[7:4];
               default: ad_nxt = addr_q[3:0];
            endcase
         end
         S_WDATA:   ad_nxt = cnt_nxt[0] ? wdata_q[7:4] : wdata_q[3:0];
         default:   ad_nxt = 4'hF;
      endcase
   end

   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         sw_cnt     <= '0;
         nr_cnt     <= '0;
         err_q      <= 1'b0;
         abt_q      <= 1'b0;
         rdata_q    <= 8'h00;
         write_q    <= 1'b0;
         addr_q     <= 16'h0000;
         wdata_q    <= 8'h00;
         lpc_frame  <= 1'b1;
         lpc_ad_oe  <= 1'b0;
         lpc_ad_out <= 4'hF;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 8'h00;
         rsp_error  <= 1'b0;
         rsp_abort  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         sw_cnt  <= sw_nxt;
         nr_cnt  <= nr_nxt;
         err_q   <= err_nxt;
         abt_q   <= abt_nxt;
         rdata_q <= rdata_nxt;
         if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         lpc_frame  <= !(state_nxt == S_START || state_nxt == S_ABORT);
         lpc_ad_oe  <= state_nxt inside {S_START, S_CYCTYPE, S_ADDR, S_WDATA, S_HTAR0, S_ABORT};
         lpc_ad_out <= ad_nxt;
         req_ready  <= (state_nxt == S_IDLE);
         rsp_valid  <= (state_nxt == S_DONE);
         rsp_rdata  <= (state_nxt == S_DONE && !abt_nxt) ? rdata_nxt : 8'h00;
         rsp_error  <= (state_nxt == S_DONE) && err_nxt;
         rsp_abort  <= (state_nxt == S_DONE) && abt_nxt;
      end
   end

endmodule
